fetch_delay_pipe: RTL and testbench

FETCH_DELAY_PIPE -- requirements
Module: fetch_delay_pipe

---
 rtl/fetch_pipe_pkg.sv | 16 +
 rtl/fetch_pipe_stage.sv | 27 ++
 rtl/fetch_delay_pipe.sv | 100 ++++++++++
 tb/tb_fetch_delay_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pipe_pkg.sv
// Shared types and constants for the IF->ID fetch delay pipe.
package fetch_pipe_pkg;

  localparam int unsigned FETCH_WIDTH = 32;

  localparam logic [FETCH_WIDTH-1:0] NOP = '0;

  // One in-flight fetch record at the default width.
  typedef struct packed {
    logic                   valid;
    logic [FETCH_WIDTH-1:0] instr;
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] pc4;
  } fetch_entry_t;

endpackage : fetch_pipe_pkg

// File: rtl/fetch_pipe_stage.sv
// Single pipe entry register: async reset, synchronous clear beats load.
module fetch_pipe_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] entry_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else if (clear_i) begin
      entry_q <= '0;
    end else if (load_i) begin
      entry_q <= d_i;
    end
  end

  assign q_o = entry_q;

endmodule : fetch_pipe_stage

// File: rtl/fetch_delay_pipe.sv
// DEPTH-stage delay line between IF and ID with stall, flush and bubble tracking.
// Define FETCH_PIPE_COLLAPSE_EN to let entries slide into bubbles while stalled.
module fetch_delay_pipe
  import fetch_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned WIDTH = FETCH_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [WIDTH-1:0]           Instr_IN,
  input  logic [WIDTH-1:0]           Instr_PC_IN,
  input  logic [WIDTH-1:0]           Instr_PC_Plus4_IN,
  input  logic                       Valid_IN,
  input  logic                       STALL,
  input  logic                       FLUSH,
  output logic [WIDTH-1:0]           Instr_OUT,
  output logic [WIDTH-1:0]           Instr_PC_OUT,
  output logic [WIDTH-1:0]           Instr_PC_Plus4_OUT,
  output logic                       Valid_OUT,
  output logic                       Stall_Upstream,
  output logic [$clog2(DEPTH+1)-1:0] Occupancy
);

  localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = 1 + 3 * WIDTH;

  // Same layout as fetch_entry_t, sized by WIDTH.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc4;
  } entry_t;

  entry_t             in_c;
  entry_t             stage_q [DEPTH];
  entry_t             last_q;
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   room_c;

  assign in_c = '{valid: Valid_IN, instr: Instr_IN, pc: Instr_PC_IN, pc4: Instr_PC_Plus4_IN};

  // room_c[k]: stage k loads from its upstream neighbour this edge.
  always_comb begin
    logic hole;
    room_c = '0;
    hole   = ~STALL;
`ifdef FETCH_PIPE_COLLAPSE_EN
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hole      = hole | ~valid_q[k];
      room_c[k] = hole;
    end
`else
    for (int k = 0; k < DEPTH; k++) begin
      room_c[k] = hole;
    end
`endif
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    entry_t stage_d;

    if (g == 0) begin : g_head
      assign stage_d = in_c;
    end else begin : g_tail
      assign stage_d = stage_q[g-1];
    end

    fetch_pipe_stage #(
      .W (ENTRY_W)
    ) u_stage (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .load_i  (room_c[g]),
      .clear_i (FLUSH),
      .d_i     (stage_d),
      .q_o     (stage_q[g])
    );

    assign valid_q[g] = stage_q[g].valid;
  end

  always_comb begin
    Occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      Occupancy = Occupancy + OCC_W'(valid_q[k]);
    end
  end

  assign last_q             = stage_q[DEPTH-1];
  assign Valid_OUT          = last_q.valid;
  assign Instr_OUT          = last_q.valid ? last_q.instr : WIDTH'(NOP);
  assign Instr_PC_OUT       = last_q.pc;
  assign Instr_PC_Plus4_OUT = last_q.pc4;

  // A flush redirects IF, so it never has to hold.
  assign Stall_Upstream = STALL & ~FLUSH & ~room_c[0];

endmodule : fetch_delay_pipe

// File: tb/tb_fetch_delay_pipe.sv
// Randomised, model-checked bench for fetch_delay_pipe (DEPTH 7, plus DEPTH 1 and 16 builds).
module tb_fetch_delay_pipe;

  localparam int D = 7;
`ifdef FETCH_PIPE_COLLAPSE_EN
  localparam bit COLLAPSE = 1'b1;
`else
  localparam bit COLLAPSE = 1'b0;
`endif

  logic        CLK;
  logic        RESET;
  logic [31:0] Instr_IN, Instr_PC_IN, Instr_PC_Plus4_IN;
  logic        Valid_IN, STALL, FLUSH;

  logic [31:0] Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT;
  logic        Valid_OUT, Stall_Upstream;
  logic [2:0]  Occupancy;

  logic [31:0] d1_instr, d1_pc, d1_pc4, d16_instr, d16_pc, d16_pc4;
  logic        d1_valid, d1_su, d16_valid, d16_su;
  logic [0:0]  d1_occ;
  logic [4:0]  d16_occ;

  fetch_delay_pipe #(.DEPTH(D), .WIDTH(32)) u_dut (
    .CLK(CLK), .RESET(RESET), .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN),
    .Instr_PC_Plus4_IN(Instr_PC_Plus4_IN), .Valid_IN(Valid_IN), .STALL(STALL), .FLUSH(FLUSH),
    .Instr_OUT(Instr_OUT), .Instr_PC_OUT(Instr_PC_OUT), .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
    .Valid_OUT(Valid_OUT), .Stall_Upstream(Stall_Upstream), .Occupancy(Occupancy));

  fetch_delay_pipe #(.DEPTH(1), .WIDTH(32)) u_d1 (
    .CLK(CLK), .RESET(RESET), .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN),
    .Instr_PC_Plus4_IN(Instr_PC_Plus4_IN), .Valid_IN(Valid_IN), .STALL(STALL), .FLUSH(FLUSH),
    .Instr_OUT(d1_instr), .Instr_PC_OUT(d1_pc), .Instr_PC_Plus4_OUT(d1_pc4),
    .Valid_OUT(d1_valid), .Stall_Upstream(d1_su), .Occupancy(d1_occ));

  fetch_delay_pipe #(.DEPTH(16), .WIDTH(32)) u_d16 (
    .CLK(CLK), .RESET(RESET), .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN),
    .Instr_PC_Plus4_IN(Instr_PC_Plus4_IN), .Valid_IN(Valid_IN), .STALL(STALL), .FLUSH(FLUSH),
    .Instr_OUT(d16_instr), .Instr_PC_OUT(d16_pc), .Instr_PC_Plus4_OUT(d16_pc4),
    .Valid_OUT(d16_valid), .Stall_Upstream(d16_su), .Occupancy(d16_occ));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model: the pipe as an array of slots, index D-1 at the output.
  bit          m_v [D];
  logic [31:0] m_i [D];
  logic [31:0] m_p [D];
  logic [31:0] m_4 [D];
  logic        obs_su, exp_su;

  function automatic int m_occ();
    int n = 0;
    for (int k = 0; k < D; k++) n += int'(m_v[k]);
    return n;
  endfunction

  function automatic logic [31:0] m_instr_out();
    return m_v[D-1] ? m_i[D-1] : 32'd0;
  endfunction

  function automatic bit m_has_hole();
    for (int k = 0; k < D; k++) if (!m_v[k]) return 1'b1;
    return 1'b0;
  endfunction

  // IF must hold only when stalled, not flushing, and the pipe cannot take the input.
  function automatic logic m_stall_up();
    if (!STALL || FLUSH) return 1'b0;
    if (COLLAPSE && m_has_hole()) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < D; k++) begin
      m_v[k] = 1'b0; m_i[k] = '0; m_p[k] = '0; m_4[k] = '0;
    end
  endtask

  // Everything upstream of the slot that gets filled slides down one; slot 0 takes the input.
  task automatic model_step();
    int h;
    if (FLUSH) begin
      for (int k = 0; k < D; k++) m_v[k] = 1'b0;
    end else begin
      h = -1;
      if (!STALL) h = D - 1;
      else if (COLLAPSE) for (int k = 0; k < D; k++) if (!m_v[k]) h = k;
      for (int k = h; k >= 1; k--) begin
        m_v[k] = m_v[k-1]; m_i[k] = m_i[k-1]; m_p[k] = m_p[k-1]; m_4[k] = m_4[k-1];
      end
      if (h >= 0) begin
        m_v[0] = Valid_IN; m_i[0] = Instr_IN; m_p[0] = Instr_PC_IN; m_4[0] = Instr_PC_Plus4_IN;
      end
    end
  endtask

  task automatic tick(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] pc4, input logic st, input logic fl);
    Valid_IN = v; Instr_IN = ins; Instr_PC_IN = pc; Instr_PC_Plus4_IN = pc4;
    STALL = st; FLUSH = fl;
    #1;
    exp_su = m_stall_up();
    obs_su = Stall_Upstream;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({Valid_OUT, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Occupancy} !== '0)
      begin fails++; $display("FAIL reset_main got v=%b i=%h pc=%h pc4=%h occ=%0d exp all 0",
        Valid_OUT, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Occupancy); end
    tests++;
    if ({d1_valid, d1_instr, d1_pc, d1_pc4, d1_occ} !== '0)
      begin fails++; $display("FAIL reset_d1 got v=%b occ=%0d exp 0", d1_valid, d1_occ); end
    tests++;
    if ({d16_valid, d16_instr, d16_pc, d16_pc4, d16_occ} !== '0)
      begin fails++; $display("FAIL reset_d16 got v=%b occ=%0d exp 0", d16_valid, d16_occ); end
    tests++;
    if (Stall_Upstream !== 1'b0)
      begin fails++; $display("FAIL reset_su got %b exp 0", Stall_Upstream); end
    RESET = 1'b0;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic test_stream();
    for (int n = 0; n < D + 8; n++) begin
      logic [31:0] pc;
      pc = 32'h100 + 32'(4 * n);
      tick(1'b1, $urandom, pc, pc + 32'd4, 1'b0, 1'b0);
      tests++;
      if ({Valid_OUT, Instr_OUT, Occupancy} !== {m_v[D-1], m_instr_out(), 3'(m_occ())})
        begin fails++; $display("FAIL stream_out n=%0d got v=%b i=%h occ=%0d exp v=%b i=%h occ=%0d",
          n, Valid_OUT, Instr_OUT, Occupancy, m_v[D-1], m_instr_out(), m_occ()); end
      tests++;
      if (Valid_OUT !== (n >= D - 1))
        begin fails++; $display("FAIL stream_latency n=%0d got v=%b exp %b", n, Valid_OUT, n >= D - 1); end
      if (n >= D - 1) begin
        tests++;
        if ({Instr_PC_OUT, Instr_PC_Plus4_OUT} !== {32'h100 + 32'(4 * (n - D + 1)), 32'h104 + 32'(4 * (n - D + 1))})
          begin fails++; $display("FAIL stream_pc n=%0d got pc=%h pc4=%h exp pc=%h", n, Instr_PC_OUT,
            Instr_PC_Plus4_OUT, 32'h100 + 32'(4 * (n - D + 1))); end
      end
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 32'hdead_beef, 32'h1ff0, 32'h1ff4, 1'b0, 1'b1);
    tests++;
    if ({Valid_OUT, Instr_OUT, Occupancy} !== '0)
      begin fails++; $display("FAIL flush_empty got v=%b i=%h occ=%0d exp 0", Valid_OUT, Instr_OUT, Occupancy); end
    for (int n = 0; n < D + 2; n++) begin
      if (n == 0) tick(1'b1, 32'h1234_5678, 32'h200, 32'h204, 1'b0, 1'b0);
      else        tick(1'b0, $urandom, $urandom, $urandom, 1'b0, 1'b0);
      tests++;
      if (Valid_OUT !== (n == D - 1))
        begin fails++; $display("FAIL flush_refill n=%0d got v=%b exp %b", n, Valid_OUT, n == D - 1); end
      if (n == D - 1) begin
        tests++;
        if ({Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT} !== {32'h1234_5678, 32'h200, 32'h204})
          begin fails++; $display("FAIL flush_newpc got i=%h pc=%h pc4=%h exp 12345678/200/204",
            Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT); end
      end
    end
  endtask

  // V,B,V,B,... in flight, then a held stall with alternating input bubbles, then release.
  task automatic test_stall_bubbles();
    for (int n = 0; n < D + 12; n++) begin
      logic [31:0] pc;
      logic        v, st;
      pc = 32'h300 + 32'(4 * n);
      v  = (n % 2) == 0;
      st = (n >= D) && (n < D + 4);
      tick(v, $urandom, pc, pc + 32'd4, st, 1'b0);
      tests++;
      if (obs_su !== exp_su)
        begin fails++; $display("FAIL stall_su n=%0d got %b exp %b", n, obs_su, exp_su); end
      tests++;
      if ({Valid_OUT, Instr_OUT, Occupancy} !== {m_v[D-1], m_instr_out(), 3'(m_occ())})
        begin fails++; $display("FAIL stall_out n=%0d got v=%b i=%h occ=%0d exp v=%b i=%h occ=%0d",
          n, Valid_OUT, Instr_OUT, Occupancy, m_v[D-1], m_instr_out(), m_occ()); end
      if (m_v[D-1]) begin
        tests++;
        if (Instr_PC_OUT !== m_p[D-1])
          begin fails++; $display("FAIL stall_pc n=%0d got %h exp %h", n, Instr_PC_OUT, m_p[D-1]); end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      pc = $urandom & 32'hffff_fffc;
      tick(1'($urandom_range(0, 1)), $urandom, pc, pc + 32'd4,
           $urandom_range(0, 9) < 4, $urandom_range(0, 15) == 0);
      tests++;
      if (obs_su !== exp_su)
        begin fails++; $display("FAIL random_su n=%0d got %b exp %b", n, obs_su, exp_su); end
      tests++;
      if ({Valid_OUT, Instr_OUT, Occupancy} !== {m_v[D-1], m_instr_out(), 3'(m_occ())})
        begin fails++; $display("FAIL random_out n=%0d got v=%b i=%h occ=%0d exp v=%b i=%h occ=%0d",
          n, Valid_OUT, Instr_OUT, Occupancy, m_v[D-1], m_instr_out(), m_occ()); end
      if (m_v[D-1]) begin
        tests++;
        if ({Instr_PC_OUT, Instr_PC_Plus4_OUT} !== {m_p[D-1], m_4[D-1]})
          begin fails++; $display("FAIL random_pc n=%0d got %h/%h exp %h/%h", n, Instr_PC_OUT,
            Instr_PC_Plus4_OUT, m_p[D-1], m_4[D-1]); end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < D; n++) tick(1'b1, $urandom, 32'h400 + 32'(4 * n), 32'h404 + 32'(4 * n), 1'b0, 1'b0);
    tests++;
    if (Occupancy !== 3'(D))
      begin fails++; $display("FAIL areset_full got occ=%0d exp %0d", Occupancy, D); end
    STALL = 1'b1; Valid_IN = 1'b1;
    #3;
    RESET = 1'b1;
    #1;
    tests++;
    if ({Valid_OUT, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Occupancy} !== '0)
      begin fails++; $display("FAIL areset_now got v=%b i=%h pc=%h pc4=%h occ=%0d exp all 0",
        Valid_OUT, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Occupancy); end
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    Instr_IN = 32'hcafe_0001; Instr_PC_IN = 32'h500; Instr_PC_Plus4_IN = 32'h504;
    @(posedge CLK);
    model_step();
    #1;
    tests++;
    if (Occupancy !== 3'(m_occ()))
      begin fails++; $display("FAIL areset_first_edge got occ=%0d exp %0d", Occupancy, m_occ()); end
    for (int n = 0; n < D + 2; n++) begin
      tick(1'b0, $urandom, $urandom, $urandom, 1'b0, 1'b0);
      tests++;
      if ({Valid_OUT, Instr_OUT, Occupancy} !== {m_v[D-1], m_instr_out(), 3'(m_occ())})
        begin fails++; $display("FAIL areset_after n=%0d got v=%b i=%h occ=%0d exp v=%b i=%h occ=%0d",
          n, Valid_OUT, Instr_OUT, Occupancy, m_v[D-1], m_instr_out(), m_occ()); end
    end
  endtask

  task automatic test_flush_stall_depths();
    for (int n = 0; n < 16; n++) tick(1'b1, $urandom, 32'h600 + 32'(4 * n), 32'h604 + 32'(4 * n), 1'b0, 1'b0);
    tests++;
    if ({d1_occ, d16_occ, Occupancy} !== {1'b1, 5'd16, 3'(D)})
      begin fails++; $display("FAIL depths_full got d1=%0d d16=%0d main=%0d exp 1/16/%0d",
        d1_occ, d16_occ, Occupancy, D); end
    Valid_IN = 1'b1; STALL = 1'b1; FLUSH = 1'b1;
    #1;
    tests++;
    if ({d1_su, d16_su, Stall_Upstream} !== 3'b000)
      begin fails++; $display("FAIL depths_su got d1=%b d16=%b main=%b exp 000", d1_su, d16_su, Stall_Upstream); end
    @(posedge CLK);
    model_step();
    #1;
    tests++;
    if ({d1_valid, d1_occ, d1_instr} !== '0)
      begin fails++; $display("FAIL depths_d1_empty got v=%b occ=%0d i=%h exp 0", d1_valid, d1_occ, d1_instr); end
    tests++;
    if ({d16_valid, d16_occ, d16_instr} !== '0)
      begin fails++; $display("FAIL depths_d16_empty got v=%b occ=%0d i=%h exp 0", d16_valid, d16_occ, d16_instr); end
    tests++;
    if ({Valid_OUT, Occupancy, Instr_OUT} !== '0)
      begin fails++; $display("FAIL depths_main_empty got v=%b occ=%0d i=%h exp 0", Valid_OUT, Occupancy, Instr_OUT); end
    STALL = 1'b0; FLUSH = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    Valid_IN = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    Instr_IN = '0; Instr_PC_IN = '0; Instr_PC_Plus4_IN = '0;
    model_reset();
    test_reset();
    test_stream();
    test_flush();
    test_stall_bubbles();
    test_random();
    test_async_reset();
    test_flush_stall_depths();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fetch_delay_pipe
